// File: rtl/hilo_mul_ctrl_if.sv
// Request bus between the EXE stage and the HI/LO multiply sequencer.
// Handshake: a request transfers in any cycle where req_valid and req_ready
// are both high. req_ready depends only on sequencer state and flush, never
// on req_valid, so EXE may hold a request and simply wait for req_ready.
// rd_data is valid in the same cycle as an accepted MFHI/MFLO transfer and
// is zero in every other cycle.
interface hilo_mul_ctrl_if;
  logic        req_valid;
  logic        op_mult;
  logic        op_mthi;
  logic        op_mtlo;
  logic        op_mfhi;
  logic        op_mflo;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req_ready;
  logic [31:0] rd_data;

  // EXE side: issues requests, consumes ready and read data
  modport master (
    output req_valid, op_mult, op_mthi, op_mtlo, op_mfhi, op_mflo, src_a, src_b,
    input  req_ready, rd_data
  );

  // Sequencer side
  modport slave (
    input  req_valid, op_mult, op_mthi, op_mtlo, op_mfhi, op_mflo, src_a, src_b,
    output req_ready, rd_data
  );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO multiply sequencer for the 5-stage pipeline.
// Owns the HI and LO registers, serves MTHI/MTLO/MFHI/MFLO from EXE and runs
// an iterative signed 32x32->64 multiply, ITER_BITS multiplier bits per cycle.
// The multiply works on magnitudes and applies the sign in a final cycle.
// While a multiply is in flight every request is stalled (req_ready=0).
// flush (WB exception/ERET) drops same-cycle requests and aborts a multiply
// without touching HI/LO.
module hilo_mul_ctrl #(
  parameter int ITER_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  hilo_mul_ctrl_if.slave    bus,
  input  logic              flush,
  output logic              busy,
  output logic [31:0]       hi_out,
  output logic [31:0]       lo_out,
  output logic [1:0]        state_dbg
);

  localparam int N  = 32 / ITER_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [31:0]     mag_a;
  logic [31:0]     mag_b;     // shifted right each CALC cycle; low slice is next
  logic            sign_q;
  logic [63:0]     acc;
  logic [CW-1:0]   count;

  logic            in_idle;
  logic            accept;
  logic            take_mult;
  logic            take_mthi;
  logic            take_mtlo;
  logic            take_mfhi;
  logic            take_mflo;
  logic            last_iter;
  logic [31:0]     abs_a;
  logic [31:0]     abs_b;
  logic [63:0]     a_ext;
  logic [63:0]     slice_ext;
  logic [63:0]     partial;
  logic [6:0]      shamt;
  logic [63:0]     acc_next;
  logic [63:0]     result;

  // Request decode: one op at most is taken, mult > mthi > mtlo > mfhi > mflo
  always_comb begin
    in_idle   = (state == ST_IDLE);
    accept    = in_idle && bus.req_valid && !flush;
    take_mult = accept && bus.op_mult;
    take_mthi = accept && !bus.op_mult && bus.op_mthi;
    take_mtlo = accept && !bus.op_mult && !bus.op_mthi && bus.op_mtlo;
    take_mfhi = accept && !bus.op_mult && !bus.op_mthi && !bus.op_mtlo && bus.op_mfhi;
    take_mflo = accept && !bus.op_mult && !bus.op_mthi && !bus.op_mtlo &&
                !bus.op_mfhi && bus.op_mflo;
  end

  // Ready and read data are combinational so EXE sees them in the same cycle.
  // MFHI/MFLO read the registered value; a same-cycle MTHI/MTLO cannot occur
  // because only one op is taken per cycle.
  assign bus.req_ready = in_idle && !flush;
  assign bus.rd_data   = take_mfhi ? hi_q :
                         take_mflo ? lo_q : 32'd0;

  // Magnitudes of the operands; 0x80000000 maps to itself as unsigned
  always_comb begin
    abs_a = bus.src_a[31] ? (~bus.src_a + 32'd1) : bus.src_a;
    abs_b = bus.src_b[31] ? (~bus.src_b + 32'd1) : bus.src_b;
  end

  // One CALC step: add |a| times the current multiplier slice at its weight
  always_comb begin
    a_ext     = {32'd0, mag_a};
    slice_ext = {{(64-ITER_BITS){1'b0}}, mag_b[ITER_BITS-1:0]};
    partial   = a_ext * slice_ext;
    shamt     = 7'(int'(count) * ITER_BITS);
    acc_next  = acc + (partial << shamt);
    last_iter = (count == CW'(N - 1));
    result    = sign_q ? (~acc + 64'd1) : acc;
  end

  // Sequencer FSM with HI/LO and multiply datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      sign_q <= 1'b0;
      acc    <= 64'd0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_mult) begin
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            sign_q <= bus.src_a[31] ^ bus.src_b[31];
            acc    <= 64'd0;
            count  <= '0;
            state  <= ST_CALC;
          end else if (take_mthi) begin
            hi_q <= bus.src_a;
          end else if (take_mtlo) begin
            lo_q <= bus.src_a;
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc   <= acc_next;
            mag_b <= mag_b >> ITER_BITS;
            count <= count + CW'(1);
            if (last_iter) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          // An abort in the final cycle leaves HI/LO as they were
          if (!flush) begin
            hi_q <= result[63:32];
            lo_q <= result[31:0];
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: directed cases for the documented scenarios plus
// a randomized op stream checked against an arithmetic HI/LO model.
module tb_hilo_mul_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  hilo_mul_ctrl_if bus ();

  hilo_mul_ctrl #(.ITER_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .busy      (busy),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 1 unit later, well before the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.req_valid = 1'b0;
    bus.op_mult   = 1'b0;
    bus.op_mthi   = 1'b0;
    bus.op_mtlo   = 1'b0;
    bus.op_mfhi   = 1'b0;
    bus.op_mflo   = 1'b0;
    bus.src_a     = 32'd0;
    bus.src_b     = 32'd0;
    flush         = 1'b0;
  endtask

  // flags = {mflo, mfhi, mtlo, mthi, mult}
  task automatic drive_flags(input logic [4:0] f);
    bus.op_mult = f[0];
    bus.op_mthi = f[1];
    bus.op_mtlo = f[2];
    bus.op_mfhi = f[3];
    bus.op_mflo = f[4];
  endtask

  // MULT issued in cycle 0; flush_at in 1..5 aborts in that cycle (0 = none).
  // hold_mflo keeps an MFLO request pending from cycle 1 onward.
  task automatic mult_run(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] flags, input int flush_at,
                          input bit hold_mflo);
    longint prod;
    bit     flushed;
    flushed = 1'b0;
    prod = longint'(signed'(a)) * longint'(signed'(b));
    bus.req_valid = 1'b1;
    drive_flags(flags);
    bus.src_a = a;
    bus.src_b = b;
    #1;
    check("mult_accept_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    clear_req();
    for (int c = 1; c <= 5; c++) begin
      if (hold_mflo) begin
        bus.req_valid = 1'b1;
        bus.op_mflo   = 1'b1;
      end
      if (c == flush_at) flush = 1'b1;
      #1;
      check("busy_in_flight", {31'd0, busy}, 32'd1);
      if (hold_mflo) begin
        check("stall_ready", {31'd0, bus.req_ready}, 32'd0);
        check("stall_rd_data", bus.rd_data, 32'd0);
      end
      step();
      flush = 1'b0;
      if (c == flush_at) begin
        flushed = 1'b1;
        break;
      end
    end
    if (!flushed) begin
      hi_m = prod[63:32];
      lo_m = prod[31:0];
    end
    #1;
    check("busy_after", {31'd0, busy}, 32'd0);
    check("mult_hi", hi_out, hi_m);
    check("mult_lo", lo_out, lo_m);
    if (hold_mflo) begin
      check("mflo_ready", {31'd0, bus.req_ready}, 32'd1);
      check("mflo_rd_data", bus.rd_data, lo_m);
    end
    step();
    clear_req();
  endtask

  // One non-MULT request in IDLE; flags must not contain mult
  task automatic single_op(input logic [4:0] flags, input logic [31:0] a);
    logic [31:0] exp_rd;
    exp_rd = 32'd0;
    if (!flags[1] && !flags[2]) begin
      if (flags[3])      exp_rd = hi_m;
      else if (flags[4]) exp_rd = lo_m;
    end
    bus.req_valid = 1'b1;
    drive_flags(flags);
    bus.src_a = a;
    bus.src_b = $urandom;
    #1;
    check("op_ready", {31'd0, bus.req_ready}, 32'd1);
    exp_q.push_back(exp_rd);
    check("op_rd_data", bus.rd_data, exp_q.pop_front());
    step();
    clear_req();
    if (flags[1])      hi_m = a;
    else if (flags[2]) lo_m = a;
    check("op_hi", hi_out, hi_m);
    check("op_lo", lo_out, lo_m);
  endtask

  // Request presented together with flush in IDLE: nothing is taken
  task automatic idle_flush(input logic [4:0] flags, input logic [31:0] a);
    bus.req_valid = 1'b1;
    drive_flags(flags);
    bus.src_a = a;
    bus.src_b = a;
    flush     = 1'b1;
    #1;
    check("flush_ready", {31'd0, bus.req_ready}, 32'd0);
    check("flush_rd_data", bus.rd_data, 32'd0);
    step();
    clear_req();
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi_out, hi_m);
    check("flush_lo", lo_out, lo_m);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0]  f;
    int          op;
    int          fa;

    clear_req();
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; an empty request is still acknowledged
    bus.req_valid = 1'b1;
    #1;
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rd_data", bus.rd_data, 32'd0);
    reset = 1'b0;
    step();
    clear_req();

    // 3 * -2
    mult_run(32'h0000_0003, 32'hFFFF_FFFE, 5'b00001, 0, 1'b0);
    check("t2_hi", hi_out, 32'hFFFF_FFFF);
    check("t2_lo", lo_out, 32'hFFFF_FFFA);

    // most negative squared
    mult_run(32'h8000_0000, 32'h8000_0000, 5'b00001, 0, 1'b0);
    check("t3_hi", hi_out, 32'h4000_0000);
    check("t3_lo", lo_out, 32'h0000_0000);

    // MFLO stalled behind a multiply
    mult_run(32'd7, 32'd6, 5'b00001, 0, 1'b1);
    check("t4_lo", lo_out, 32'h0000_002A);

    // flush in cycle 2 aborts, HI/LO untouched
    single_op(5'b00010, 32'h1234_5678);
    mult_run(32'd5, 32'd5, 5'b00001, 2, 1'b0);
    check("t5_hi", hi_out, 32'h1234_5678);
    check("t5_lo", lo_out, 32'h0000_002A);

    // flush in FIN beats the HI/LO write
    mult_run(32'd9, 32'd9, 5'b00001, 5, 1'b0);
    check("fin_flush_lo", lo_out, 32'h0000_002A);

    // MTHI then MFHI
    single_op(5'b00010, 32'h1234_5678);
    single_op(5'b01000, 32'd0);

    // priority with several flags set
    single_op(5'b00110, 32'hA5A5_0001);
    check("prio_hi", hi_out, 32'hA5A5_0001);
    single_op(5'b11100, 32'h0BAD_CAFE);
    check("prio_lo", lo_out, 32'h0BAD_CAFE);

    // flush while idle
    idle_flush(5'b00010, 32'hDEAD_BEEF);
    idle_flush(5'b00001, 32'h0000_0002);

    // asynchronous reset in the middle of CALC
    bus.req_valid = 1'b1;
    bus.op_mult   = 1'b1;
    bus.src_a     = 32'd11;
    bus.src_b     = 32'd13;
    step();
    clear_req();
    step();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi_out, 32'd0);
    check("mid_rst_lo", lo_out, 32'd0);
    step();
    reset = 1'b0;
    step();

    // randomized op stream
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        f  = 5'b00001 | (5'($urandom) & 5'b11110);
        fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        mult_run(pick_operand(), pick_operand(), f, fa, 1'b0);
      end else if (op == 3) begin
        f = 5'($urandom);
        idle_flush(f, $urandom);
      end else begin
        op = $urandom_range(1, 5);
        if (op == 5) f = 5'b00000;
        else         f = (5'b00001 << op) | (5'($urandom) & (5'b11110 << op));
        single_op(f, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
